piso_serializer: RTL

Parallel-in/serial-out stage that sits directly upstream of the serial pattern detectors (e.g. the 1101 Moore detector). It accepts WIDTH-bit words over a valid/ready handshake. It emits one bit per clock on ser_out, which drives the detector's x input. Back-to-back words are emitted gaplessly, so detectors see a continuous stream, including patterns that straddle a word boundary.

---
 rtl/piso_serializer.sv | 98 +++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage with valid/ready intake.
// Registered serial bit, bit_valid and last_bit; gapless back-to-back words.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    output logic             bit_valid,
    output logic             last_bit,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             at_last;
    logic             accept;
    logic             ser_d;

    assign at_last  = (state_q == SHIFT) && (cnt_q == CNT_MAX);
    assign in_ready = (state_q == IDLE) || at_last;
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == SHIFT);

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    sreg_d  = in_data;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (!at_last) begin
                    cnt_d  = cnt_q + 1'b1;
                    sreg_d = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                       : {1'b0, sreg_q[WIDTH-1:1]};
                end else if (accept) begin
                    sreg_d = in_data;
                    cnt_d  = '0;
                end else begin
                    state_d = IDLE;
                    sreg_d  = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                sreg_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state view so they align with cnt_q
    always_comb begin
        ser_d = IDLE_BIT;
        if (state_d == SHIFT)
            ser_d = MSB_FIRST ? sreg_d[WIDTH-1] : sreg_d[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            cnt_q     <= '0;
            ser_out   <= IDLE_BIT;
            bit_valid <= 1'b0;
            last_bit  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            cnt_q     <= cnt_d;
            ser_out   <= ser_d;
            bit_valid <= (state_d == SHIFT);
            last_bit  <= (state_d == SHIFT) && (cnt_d == CNT_MAX);
        end
    end

endmodule
